fp_mult_seq: RTL and testbench

- Sequential IEEE-754-style floating-point multiplier, parametrised in exponent and mantissa width. Successor to the existing `mult` block.
- Adds over `mult`: synchronous reset, busy/done handshake, four selectable rounding modes, an inexact flag, a canonical NaN output, and deterministic latency.
- Sits in the FP ALU datapath next to the adder. It is driven by the ALU op decoder through load/enable.

---
 rtl/fp_mult_seq.sv | 228 ++++++++++++++++++++++
 tb/tb_fp_mult_seq.sv | 186 ++++++++++++++++++
 2 files changed

// File: rtl/fp_mult_seq.sv
// rtl/fp_mult_seq.sv - sequential IEEE-754-style multiplier with rounding modes and busy/done handshake
// Optional build macro: FP_MULT_RADIX4_EN (radix-4 multiply step, two multiplier bits per cycle).
module fp_mult_seq #(
    parameter int Mantissa_Size = 23,
    parameter int Exponent_Size = 8,
    parameter int Bias          = (1 << (Exponent_Size - 1)) - 1
) (
    input  logic                                   clk,
    input  logic                                   rst,
    input  logic                                   enable,
    input  logic                                   load,
    input  logic [1:0]                             rmode,
    input  logic [Exponent_Size+Mantissa_Size:0]   A,
    input  logic [Exponent_Size+Mantissa_Size:0]   B,
    output logic [Exponent_Size+Mantissa_Size:0]   result,
    output logic                                   done,
    output logic                                   busy,
    output logic                                   zero,
    output logic                                   overflow,
    output logic                                   underflow,
    output logic                                   NAN,
    output logic                                   inexact
);

    localparam int M  = Mantissa_Size;
    localparam int E  = Exponent_Size;
    localparam int W  = E + M + 1;
    localparam int EW = E + 2;
    localparam int PW = 2 * M + 2;
`ifdef FP_MULT_RADIX4_EN
    localparam int STEP        = 2;
    localparam int MULT_CYCLES = (M + 2) / 2;
`else
    localparam int STEP        = 1;
    localparam int MULT_CYCLES = M + 1;
`endif
    localparam int CW = $clog2(MULT_CYCLES + 1);

    localparam logic signed [EW-1:0] BIAS_E   = EW'(Bias);
    localparam logic signed [EW-1:0] EXP_MAX  = EW'((1 << E) - 1);
    localparam logic signed [EW-1:0] EXP_ONE  = EW'(1);
    localparam logic signed [EW-1:0] EXP_ZERO = '0;
    localparam logic [W-1:0] CANON_NAN = {1'b0, {E{1'b1}}, 1'b1, {(M-1){1'b0}}};

    typedef enum logic [2:0] {
        S_IDLE, S_UNPACK, S_MULT, S_NORM, S_ROUND, S_DONE
    } state_t;

    state_t                 state;
    logic [W-1:0]           a_r, b_r;
    logic [1:0]             rmode_r;
    logic                   sign_r;
    logic signed [EW-1:0]   exp_r;
    logic [PW-1:0]          acc, mcand, pp;
    logic [M:0]             mplier;
    logic [CW-1:0]          cnt;
    logic                   sticky_lo;

    logic [E-1:0] ea, eb;
    logic [M-1:0] fa, fb;
    logic a_nan, b_nan, a_inf, b_inf, a_zero, b_zero, sign_c;

    assign ea     = a_r[W-2:M];
    assign eb     = b_r[W-2:M];
    assign fa     = a_r[M-1:0];
    assign fb     = b_r[M-1:0];
    assign a_nan  = (&ea) & (|fa);
    assign b_nan  = (&eb) & (|fb);
    assign a_inf  = (&ea) & ~(|fa);
    assign b_inf  = (&eb) & ~(|fb);
    // Subnormal operands are flushed, so exp==0 alone classifies as zero.
    assign a_zero = ~(|ea);
    assign b_zero = ~(|eb);
    assign sign_c = a_r[W-1] ^ b_r[W-1];

    always_comb begin
        pp = '0;
`ifdef FP_MULT_RADIX4_EN
        unique case (mplier[1:0])
            2'd0: pp = '0;
            2'd1: pp = mcand;
            2'd2: pp = mcand << 1;
            2'd3: pp = mcand + (mcand << 1);
        endcase
`else
        pp = mplier[0] ? mcand : '0;
`endif
    end

    logic [M:0]           mant;
    logic                 g_bit, r_bit, s_bit, inx_c, inc_c, ovf_c, unf_c, sel_inf;
    logic [M+1:0]         mant_sum;
    logic [M-1:0]         frac_c;
    logic signed [EW-1:0] exp_c;

    // Rounding operates on the normalised accumulator (hidden bit at 2M).
    always_comb begin
        mant     = acc[2*M -: M+1];
        g_bit    = acc[M-1];
        r_bit    = acc[M-2];
        s_bit    = (|acc[M-3:0]) | sticky_lo;
        inx_c    = g_bit | r_bit | s_bit;
        inc_c    = 1'b0;
        unique case (rmode_r)
            2'b00: inc_c = g_bit & (r_bit | s_bit | mant[0]);
            2'b01: inc_c = 1'b0;
            2'b10: inc_c = inx_c & ~sign_r;
            2'b11: inc_c = inx_c & sign_r;
        endcase
        mant_sum = {1'b0, mant} + {{(M+1){1'b0}}, inc_c};
        frac_c   = mant_sum[M-1:0];
        exp_c    = exp_r;
        if (mant_sum[M+1]) begin
            frac_c = mant_sum[M:1];
            exp_c  = exp_r + EXP_ONE;
        end
        ovf_c   = (exp_c >= EXP_MAX);
        unf_c   = (exp_c <= EXP_ZERO);
        sel_inf = (rmode_r == 2'b00) | ((rmode_r == 2'b10) & ~sign_r) |
                  ((rmode_r == 2'b11) & sign_r);
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= S_IDLE;
            result    <= '0;
            done      <= 1'b0;
            busy      <= 1'b0;
            zero      <= 1'b0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
            NAN       <= 1'b0;
            inexact   <= 1'b0;
            a_r       <= '0;
            b_r       <= '0;
            rmode_r   <= 2'b00;
            sign_r    <= 1'b0;
            exp_r     <= '0;
            acc       <= '0;
            mcand     <= '0;
            mplier    <= '0;
            cnt       <= '0;
            sticky_lo <= 1'b0;
        end else if (enable) begin
            unique case (state)
                S_IDLE, S_DONE: begin
                    if (load) begin
                        a_r       <= A;
                        b_r       <= B;
                        rmode_r   <= rmode;
                        done      <= 1'b0;
                        zero      <= 1'b0;
                        overflow  <= 1'b0;
                        underflow <= 1'b0;
                        NAN       <= 1'b0;
                        inexact   <= 1'b0;
                        busy      <= 1'b1;
                        state     <= S_UNPACK;
                    end
                end
                S_UNPACK: begin
                    sign_r    <= sign_c;
                    exp_r     <= $signed({2'b00, ea}) + $signed({2'b00, eb}) - BIAS_E;
                    mcand     <= {{(M+1){1'b0}}, 1'b1, fa};
                    mplier    <= {1'b1, fb};
                    acc       <= '0;
                    cnt       <= '0;
                    sticky_lo <= 1'b0;
                    if (a_nan | b_nan | (a_inf & b_zero) | (b_inf & a_zero)) begin
                        result <= CANON_NAN;
                        NAN    <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else if (a_inf | b_inf) begin
                        result <= {sign_c, {E{1'b1}}, {M{1'b0}}};
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else if (a_zero | b_zero) begin
                        result <= {sign_c, {(W-1){1'b0}}};
                        zero   <= 1'b1;
                        done   <= 1'b1;
                        busy   <= 1'b0;
                        state  <= S_DONE;
                    end else begin
                        state  <= S_MULT;
                    end
                end
                S_MULT: begin
                    acc    <= acc + pp;
                    mcand  <= mcand << STEP;
                    mplier <= mplier >> STEP;
                    cnt    <= cnt + 1'b1;
                    if (cnt == CW'(MULT_CYCLES - 1))
                        state <= S_NORM;
                end
                S_NORM: begin
                    if (acc[PW-1]) begin
                        acc       <= acc >> 1;
                        sticky_lo <= acc[0];
                        exp_r     <= exp_r + EXP_ONE;
                    end
                    state <= S_ROUND;
                end
                S_ROUND: begin
                    inexact <= inx_c | ovf_c | unf_c;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= S_DONE;
                    if (ovf_c) begin
                        overflow <= 1'b1;
                        result   <= sel_inf ? {sign_r, {E{1'b1}}, {M{1'b0}}}
                                            : {sign_r, {(E-1){1'b1}}, 1'b0, {M{1'b1}}};
                    end else if (unf_c) begin
                        underflow <= 1'b1;
                        zero      <= 1'b1;
                        result    <= {sign_r, {(W-1){1'b0}}};
                    end else begin
                        result <= {sign_r, exp_c[E-1:0], frac_c};
                    end
                end
                default: state <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_fp_mult_seq.sv
// tb/tb_fp_mult_seq.sv - table-driven scoreboard bench for fp_mult_seq
module tb_fp_mult_seq;

`ifdef FP_MULT_RADIX4_EN
    localparam int NL = 16;
`else
    localparam int NL = 28;
`endif
    localparam int SL = 2;

    logic        clk = 1'b0;
    logic        rst, enable, load;
    logic [1:0]  rmode;
    logic [31:0] A, B, result;
    logic        done, busy, zero, overflow, underflow, NAN, inexact;
    logic [4:0]  fl_o;

    assign fl_o = {zero, overflow, underflow, NAN, inexact};

    fp_mult_seq dut (
        .clk(clk), .rst(rst), .enable(enable), .load(load), .rmode(rmode),
        .A(A), .B(B), .result(result), .done(done), .busy(busy), .zero(zero),
        .overflow(overflow), .underflow(underflow), .NAN(NAN), .inexact(inexact)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  rm;
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } vec_t;

    typedef struct {
        logic [31:0] res;
        logic [4:0]  fl;
        int          lat;
    } exp_t;

    // flag order: {zero, overflow, underflow, NAN, inexact}
    localparam logic [4:0] F_NONE = 5'b00000;
    localparam logic [4:0] F_INX  = 5'b00001;
    localparam logic [4:0] F_NAN  = 5'b00010;
    localparam logic [4:0] F_OVF  = 5'b01001;
    localparam logic [4:0] F_UNF  = 5'b10101;
    localparam logic [4:0] F_ZERO = 5'b10000;

    vec_t vt[$];
    exp_t sb[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    function automatic vec_t mk(logic [31:0] a, logic [31:0] b, logic [1:0] rm,
                                logic [31:0] res, logic [4:0] fl, int lat);
        vec_t v;
        v.a = a; v.b = b; v.rm = rm; v.res = res; v.fl = fl; v.lat = lat;
        return v;
    endfunction

    task automatic check(input string tag, input string what,
                         input logic [63:0] act, input logic [63:0] exp_v);
        n_cmp++;
        if (act !== exp_v) begin
            n_bad++;
            $display("FAIL %s.%s: got %h expected %h", tag, what, act, exp_v);
        end
    endtask

    task automatic run_vec(input vec_t v, input int stall_at, input int stall_len,
                           input int spur_at, input string tag);
        exp_t e;
        int   n;
        int   busy_n;
        bit   got;
        @(negedge clk);
        A = v.a; B = v.b; rmode = v.rm; load = 1'b1; enable = 1'b1;
        e.res = v.res; e.fl = v.fl; e.lat = v.lat + stall_len;
        sb.push_back(e);
        n = 0; busy_n = 0; got = 1'b0;
        while (!got && n < 300) begin
            @(posedge clk);
            #1;
            n++;
            if (n == 1) load = 1'b0;
            if (busy) busy_n++;
            if (n == stall_at) enable = 1'b0;
            if (stall_len > 0 && n == stall_at + stall_len) enable = 1'b1;
            if (n == spur_at) begin
                load = 1'b1; A = 32'h7F000000; B = 32'h40000000; rmode = 2'b01;
            end
            if (spur_at > 0 && n == spur_at + 1) load = 1'b0;
            if (done) got = 1'b1;
        end
        enable = 1'b1;
        load   = 1'b0;
        e = sb.pop_front();
        if (!got) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s.timeout: got no done after %0d edges expected %0d", tag, n, e.lat);
            return;
        end
        check(tag, "result",  64'(result), 64'(e.res));
        check(tag, "flags",   64'(fl_o),   64'(e.fl));
        check(tag, "latency", 64'(n),      64'(e.lat));
        check(tag, "busy_edges", 64'(busy_n), 64'(e.lat - 1));
        @(posedge clk);
        #1;
        check(tag, "hold", {31'd0, done, result}, {31'd0, 1'b1, e.res});
    endtask

    initial begin
        int  seen;
        rst = 1'b1; enable = 1'b0; load = 1'b0; rmode = 2'b00; A = '0; B = '0;

        vt.push_back(mk(32'h40400000, 32'hC0200000, 2'b00, 32'hC0F00000, F_NONE, NL));
        vt.push_back(mk(32'h7F000000, 32'h40000000, 2'b00, 32'h7F800000, F_OVF,  NL));
        vt.push_back(mk(32'h7F000000, 32'h40000000, 2'b01, 32'h7F7FFFFF, F_OVF,  NL));
        vt.push_back(mk(32'h7F000000, 32'h40000000, 2'b10, 32'h7F800000, F_OVF,  NL));
        vt.push_back(mk(32'h7F000000, 32'h40000000, 2'b11, 32'h7F7FFFFF, F_OVF,  NL));
        vt.push_back(mk(32'hFF000000, 32'h40000000, 2'b10, 32'hFF7FFFFF, F_OVF,  NL));
        vt.push_back(mk(32'hFF000000, 32'h40000000, 2'b11, 32'hFF800000, F_OVF,  NL));
        vt.push_back(mk(32'h00800000, 32'hBF000000, 2'b00, 32'h80000000, F_UNF,  NL));
        vt.push_back(mk(32'h7F800000, 32'h00000000, 2'b00, 32'h7FC00000, F_NAN,  SL));
        vt.push_back(mk(32'h7F800000, 32'hBF800000, 2'b00, 32'hFF800000, F_NONE, SL));
        vt.push_back(mk(32'hFF800000, 32'h7F800000, 2'b00, 32'hFF800000, F_NONE, SL));
        vt.push_back(mk(32'h7FC12345, 32'h3F800000, 2'b00, 32'h7FC00000, F_NAN,  SL));
        vt.push_back(mk(32'h00000000, 32'hC0000000, 2'b00, 32'h80000000, F_ZERO, SL));
        vt.push_back(mk(32'h00000001, 32'h3F800000, 2'b00, 32'h00000000, F_ZERO, SL));
        vt.push_back(mk(32'h3F800001, 32'h3F800001, 2'b00, 32'h3F800002, F_INX,  NL));
        vt.push_back(mk(32'h3F800001, 32'h3F800001, 2'b01, 32'h3F800002, F_INX,  NL));
        vt.push_back(mk(32'h3F800001, 32'h3F800001, 2'b10, 32'h3F800003, F_INX,  NL));
        vt.push_back(mk(32'h3F800001, 32'h3F800001, 2'b11, 32'h3F800002, F_INX,  NL));
        vt.push_back(mk(32'h3FFFFFFE, 32'h3F800001, 2'b00, 32'h40000000, F_INX,  NL));
        vt.push_back(mk(32'h3FFFFFFE, 32'h3F800001, 2'b01, 32'h3FFFFFFF, F_INX,  NL));
        vt.push_back(mk(32'h3FFFFFFF, 32'h3FFFFFFF, 2'b00, 32'h407FFFFE, F_INX,  NL));

        // Reset must win even with enable low.
        repeat (3) @(posedge clk);
        #1;
        check("reset", "outputs", {25'd0, result, done, busy, fl_o}, 64'd0);
        rst = 1'b0;

        for (int i = 0; i < vt.size(); i++)
            run_vec(vt[i], 0, 0, 0, $sformatf("vec%0d", i));

        run_vec(vt[0], 0, 0, 5, "spur_load");
        run_vec(vt[0], 6, 4, 0, "stall4");

        @(negedge clk);
        enable = 1'b0; load = 1'b1; A = 32'h7F000000; B = 32'h40000000;
        repeat (3) @(posedge clk);
        #1;
        check("en0_load", "busy_done", {62'd0, busy, done}, 64'd1);
        load = 1'b0; enable = 1'b1;

        @(negedge clk);
        A = vt[0].a; B = vt[0].b; rmode = vt[0].rm; load = 1'b1;
        for (int n = 1; n <= 9; n++) begin
            @(posedge clk);
            #1;
            if (n == 1) load = 1'b0;
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("rst10", "outputs", {25'd0, result, done, busy, fl_o}, 64'd0);
        rst = 1'b0;
        seen = 0;
        for (int n = 0; n < 40; n++) begin
            @(posedge clk);
            #1;
            if (done) seen++;
        end
        check("rst10", "no_done", 64'(seen), 64'd0);

        run_vec(vt[14], 0, 0, 0, "after_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
